// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the RAM controller state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_RDONE = 3'd3,
        ST_ERR1  = 3'd4,
        ST_ERR2  = 3'd5
    } ahb_state_e;

endpackage

// File: rtl/ahb_byte_lane.sv
// Little-endian byte-lane decode for an AHB transfer size and low address bits.
module ahb_byte_lane
    import ahb_pkg::*;
(
    input  logic [2:0] i_hsize,
    input  logic [1:0] i_addr,
    output logic [3:0] o_byte_en,
    output logic       o_misalign
);

    // Sizes above a word decode to no lanes; the caller flags them separately.
    always_comb begin
        o_byte_en  = 4'b0000;
        o_misalign = 1'b0;
        case (i_hsize)
            HSIZE_BYTE: o_byte_en = 4'b0001 << i_addr;
            HSIZE_HALF: begin
                o_byte_en  = i_addr[1] ? 4'b1100 : 4'b0011;
                o_misalign = i_addr[0];
            end
            HSIZE_WORD: begin
                o_byte_en  = 4'b1111;
                o_misalign = |i_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ahb_ram_ctrl.sv
// AHB-Lite slave that sequences address/data phases into a single-port RAM,
// inserting read wait states and the two-cycle ERROR response.
module ahb_ram_ctrl
    import ahb_pkg::*;
#(
    parameter int RAM_AW = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsel,
    input  logic [31:0]       haddr,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [31:0]       hwdata,
    input  logic              hreadyin,
    output logic              hready_out,
    output logic              hresp,
    output logic [31:0]       hrdata,
    output logic              wr_en_ram,
    output logic              rd_en_ram,
    output logic [RAM_AW-1:0] address_ram,
    output logic [3:0]        byte_en,
    output logic [31:0]       wr_data_ram,
    input  logic [31:0]       rd_data_ram,
    output logic [2:0]        o_dbg_state
);

    localparam logic [2:0] LAT = 3'(RD_LAT);

    ahb_state_e        r_state;
    ahb_state_e        w_next;
    ahb_state_e        w_after_sample;
    logic [RAM_AW-1:0] r_addr;
    logic [3:0]        r_be;
    logic [2:0]        r_cnt;
    logic [3:0]        w_be;
    logic              w_misalign;
    logic              w_out_of_range;
    logic              w_illegal;
    logic              w_sample;
    logic              w_rd_done;

    ahb_byte_lane u_lane (
        .i_hsize   (hsize),
        .i_addr    (haddr[1:0]),
        .o_byte_en (w_be),
        .o_misalign(w_misalign)
    );

    assign w_out_of_range = |haddr[31:RAM_AW+2];
    assign w_illegal      = (hsize > HSIZE_WORD) | w_misalign | w_out_of_range;
    // New address phases are only accepted in states that drive hready_out high.
    assign w_sample       = hsel & hreadyin & htrans[1] & hready_out;
    assign w_rd_done      = (r_state == ST_RD) && (r_cnt == LAT);
    assign address_ram    = r_addr;
    assign o_dbg_state    = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_after_sample = ST_IDLE;
        if (w_sample) begin
            if (w_illegal)   w_after_sample = ST_ERR1;
            else if (hwrite) w_after_sample = ST_WR;
            else             w_after_sample = ST_RD;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_WR, ST_RDONE, ST_ERR2: w_next = w_after_sample;
            ST_RD:   if (w_rd_done) w_next = ST_RDONE;
            ST_ERR1: w_next = ST_ERR2;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        hready_out  = 1'b1;
        hresp       = HRESP_OKAY;
        wr_en_ram   = 1'b0;
        rd_en_ram   = 1'b0;
        byte_en     = 4'b0000;
        wr_data_ram = 32'h0;
        case (r_state)
            ST_WR: begin
                wr_en_ram   = 1'b1;
                byte_en     = r_be;
                wr_data_ram = hwdata;
            end
            ST_RD: begin
                hready_out = 1'b0;
                rd_en_ram  = (r_cnt == 3'd0);
            end
            ST_ERR1: begin
                hready_out = 1'b0;
                hresp      = HRESP_ERROR;
            end
            ST_ERR2: hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    // r_cnt is zero on entry to RD and counts the cycles since rd_en_ram.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_be   <= 4'b0000;
            r_cnt  <= 3'd0;
            hrdata <= 32'h0;
        end else begin
            if (w_sample) begin
                r_addr <= haddr[RAM_AW+1:2];
                r_be   <= w_be;
            end
            r_cnt <= ((r_state == ST_RD) && !w_rd_done) ? r_cnt + 3'd1 : 3'd0;
            if (w_rd_done) hrdata <= rd_data_ram;
        end
    end

endmodule

// File: tb/tb_ahb_ram_ctrl.sv
// Directed bench for ahb_ram_ctrl with a behavioural one-cycle-latency RAM.
module tb_ahb_ram_ctrl;
  import ahb_pkg::*;

  logic        clk;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hreadyin;
  logic        hready_out;
  logic        hresp;
  logic [31:0] hrdata;
  logic        wr_en_ram;
  logic        rd_en_ram;
  logic [9:0]  address_ram;
  logic [3:0]  byte_en;
  logic [31:0] wr_data_ram;
  logic [31:0] rd_data_ram;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:1023];

  ahb_ram_ctrl #(.RAM_AW(10), .RD_LAT(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .hsel       (hsel),
    .haddr      (haddr),
    .htrans     (htrans),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hwdata     (hwdata),
    .hreadyin   (hreadyin),
    .hready_out (hready_out),
    .hresp      (hresp),
    .hrdata     (hrdata),
    .wr_en_ram  (wr_en_ram),
    .rd_en_ram  (rd_en_ram),
    .address_ram(address_ram),
    .byte_en    (byte_en),
    .wr_data_ram(wr_data_ram),
    .rd_data_ram(rd_data_ram),
    .o_dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_mem stand-in: byte-lane writes, registered read (latency 1)
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rd_data_ram = 32'h0;
  end

  always @(posedge clk) begin
    if (wr_en_ram) begin
      for (int b = 0; b < 4; b++)
        if (byte_en[b]) mem[address_ram][8*b +: 8] <= wr_data_ram[8*b +: 8];
    end
    if (rd_en_ram) rd_data_ram <= mem[address_ram];
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_addr(input logic [31:0] a, input logic w, input logic [2:0] s);
    hsel   = 1'b1;
    htrans = HTRANS_NONSEQ;
    haddr  = a;
    hwrite = w;
    hsize  = s;
  endtask

  task automatic drive_idle();
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    haddr  = 32'h0;
    hwrite = 1'b0;
    hsize  = 3'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    hreadyin = 1'b1;
    hwdata   = 32'h0;
    drive_idle();
    #1 rst = 1'b1;
    #2;
    chk("rst_hready", 32'(hready_out), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_wr_en", 32'(wr_en_ram), 32'd0);
    chk("rst_rd_en", 32'(rd_en_ram), 32'd0);
    chk("rst_addr", 32'(address_ram), 32'd0);
    chk("rst_byte_en", 32'(byte_en), 32'd0);
    chk("rst_wr_data", wr_data_ram, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // word write 0xDEADBEEF @0x10
    drive_addr(32'h10, 1'b1, HSIZE_WORD);
    @(negedge clk);
    chk("t1_idle_ready", 32'(hready_out), 32'd1);
    step();
    drive_idle();
    hwdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_wr_en", 32'(wr_en_ram), 32'd1);
    chk("t1_addr", 32'(address_ram), 32'd4);
    chk("t1_byte_en", 32'(byte_en), 32'hF);
    chk("t1_wr_data", wr_data_ram, 32'hDEADBEEF);
    chk("t1_hready", 32'(hready_out), 32'd1);
    chk("t1_hresp", 32'(hresp), 32'd0);
    chk("t1_rd_en", 32'(rd_en_ram), 32'd0);
    step();
    hwdata = 32'h0;
    @(negedge clk);
    chk("t1_wr_single", 32'(wr_en_ram), 32'd0);

    // word read @0x10
    drive_addr(32'h10, 1'b0, HSIZE_WORD);
    step();
    drive_idle();
    @(negedge clk);
    chk("t2_rd_en", 32'(rd_en_ram), 32'd1);
    chk("t2_wait0", 32'(hready_out), 32'd0);
    chk("t2_addr", 32'(address_ram), 32'd4);
    step();
    @(negedge clk);
    chk("t2_rd_single", 32'(rd_en_ram), 32'd0);
    chk("t2_wait1", 32'(hready_out), 32'd0);
    step();
    @(negedge clk);
    chk("t2_done_ready", 32'(hready_out), 32'd1);
    chk("t2_hrdata", hrdata, 32'hDEADBEEF);
    chk("t2_hresp", 32'(hresp), 32'd0);

    // half write 0xABCD @0x12, byte write 0x5A @0x11, read @0x10
    drive_addr(32'h12, 1'b1, HSIZE_HALF);
    step();
    hwdata = 32'hABCD0000;
    drive_addr(32'h11, 1'b1, HSIZE_BYTE);
    @(negedge clk);
    chk("t3_half_be", 32'(byte_en), 32'hC);
    chk("t3_half_wr", 32'(wr_en_ram), 32'd1);
    chk("t3_half_addr", 32'(address_ram), 32'd4);
    step();
    hwdata = 32'h00005A00;
    drive_addr(32'h10, 1'b0, HSIZE_WORD);
    @(negedge clk);
    chk("t3_byte_be", 32'(byte_en), 32'h2);
    chk("t3_byte_wr", 32'(wr_en_ram), 32'd1);
    chk("t3_byte_data", wr_data_ram, 32'h00005A00);
    step();
    drive_idle();
    hwdata = 32'h0;
    @(negedge clk);
    chk("t3_rd_en", 32'(rd_en_ram), 32'd1);
    chk("t3_no_wr", 32'(wr_en_ram), 32'd0);
    step();
    step();
    @(negedge clk);
    chk("t3_hrdata", hrdata, 32'hABCD5AEF);
    chk("t3_ready", 32'(hready_out), 32'd1);

    // misaligned word @0x13, then out-of-range @0x1000 sampled in ERR2
    drive_addr(32'h13, 1'b0, HSIZE_WORD);
    step();
    drive_idle();
    @(negedge clk);
    chk("t4a_err1_ready", 32'(hready_out), 32'd0);
    chk("t4a_err1_resp", 32'(hresp), 32'd1);
    chk("t4a_err1_rd", 32'(rd_en_ram), 32'd0);
    chk("t4a_err1_wr", 32'(wr_en_ram), 32'd0);
    step();
    drive_addr(32'h0000_1000, 1'b0, HSIZE_WORD);
    @(negedge clk);
    chk("t4a_err2_ready", 32'(hready_out), 32'd1);
    chk("t4a_err2_resp", 32'(hresp), 32'd1);
    chk("t4a_hrdata_hold", hrdata, 32'hABCD5AEF);
    step();
    drive_idle();
    @(negedge clk);
    chk("t4b_err1_ready", 32'(hready_out), 32'd0);
    chk("t4b_err1_resp", 32'(hresp), 32'd1);
    chk("t4b_err1_rd", 32'(rd_en_ram), 32'd0);
    step();
    drive_addr(32'h20, 1'b1, HSIZE_WORD);
    @(negedge clk);
    chk("t4b_err2_ready", 32'(hready_out), 32'd1);
    chk("t4b_err2_resp", 32'(hresp), 32'd1);

    // write @0x20 accepted from ERR2, pipelined read of 0x20 behind it
    step();
    hwdata = 32'h12345678;
    drive_addr(32'h20, 1'b0, HSIZE_WORD);
    @(negedge clk);
    chk("t5_wr_en", 32'(wr_en_ram), 32'd1);
    chk("t5_addr", 32'(address_ram), 32'd8);
    chk("t5_okay", 32'(hresp), 32'd0);
    chk("t5_ready", 32'(hready_out), 32'd1);
    chk("t5_wr_data", wr_data_ram, 32'h12345678);
    step();
    drive_idle();
    hwdata = 32'h0;
    @(negedge clk);
    chk("t5_rd_en", 32'(rd_en_ram), 32'd1);
    chk("t5_rd_addr", 32'(address_ram), 32'd8);
    chk("t5_no_wr", 32'(wr_en_ram), 32'd0);
    chk("t5_wait0", 32'(hready_out), 32'd0);
    step();
    @(negedge clk);
    chk("t5_wait1", 32'(hready_out), 32'd0);
    chk("t5_rd_single", 32'(rd_en_ram), 32'd0);
    step();
    @(negedge clk);
    chk("t5_hrdata", hrdata, 32'h12345678);
    chk("t5_done_ready", 32'(hready_out), 32'd1);
    chk("t5_done_resp", 32'(hresp), 32'd0);

    // illegal hsize=3
    drive_addr(32'h0, 1'b1, 3'd3);
    step();
    drive_idle();
    hwdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("t6_size_resp", 32'(hresp), 32'd1);
    chk("t6_size_ready", 32'(hready_out), 32'd0);
    chk("t6_size_no_wr", 32'(wr_en_ram), 32'd0);
    step();
    hwdata = 32'h0;
    @(negedge clk);
    chk("t6_err2_ready", 32'(hready_out), 32'd1);
    chk("t6_err2_resp", 32'(hresp), 32'd1);
    step();
    @(negedge clk);
    chk("t6_idle_resp", 32'(hresp), 32'd0);
    chk("t6_idle_state", 32'(dbg_state), 32'd0);

    // reset asserted during a read wait state
    drive_addr(32'h10, 1'b0, HSIZE_WORD);
    step();
    drive_idle();
    @(negedge clk);
    chk("t7_rd_en", 32'(rd_en_ram), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_ready", 32'(hready_out), 32'd1);
    chk("t7_rst_rd_en", 32'(rd_en_ram), 32'd0);
    chk("t7_rst_hrdata", hrdata, 32'h0);
    chk("t7_rst_hresp", 32'(hresp), 32'd0);
    chk("t7_rst_addr", 32'(address_ram), 32'd0);
    chk("t7_rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    chk("t7_rst_no_rd", 32'(rd_en_ram), 32'd0);
    chk("t7_rst_ready2", 32'(hready_out), 32'd1);
    rst = 1'b0;
    drive_addr(32'h20, 1'b0, HSIZE_WORD);
    step();
    drive_idle();
    @(negedge clk);
    chk("t7_fresh_rd_en", 32'(rd_en_ram), 32'd1);
    chk("t7_fresh_addr", 32'(address_ram), 32'd8);
    step();
    step();
    @(negedge clk);
    chk("t7_fresh_hrdata", hrdata, 32'h12345678);
    chk("t7_fresh_ready", 32'(hready_out), 32'd1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_ram_ctrl.md
Name: ahb_ram_ctrl

Overview:
AHB-Lite slave controller that sequences pipelined address/data phases into the single-port data_mem RAM. It decodes transfers, generates byte enables and RAM strobes, and inserts read wait states. It drives hready_out and hresp, including the two-cycle ERROR response for illegal transfers. It sits between the bus-side slave glue and data_mem; there is one RAM access at a time.

Parameters:
RAM_AW, 10, RAM word-address width; RAM spans 2^(RAM_AW+2) bytes from 0x0000_0000.
RD_LAT, 1, RAM read latency in cycles from rd_en_ram to valid rd_data_ram; legal range 1..7.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
hsel  in  1  slave select
haddr  in  32  byte address (address phase)
htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
hwrite  in  1  1=write
hsize  in  3  0=byte, 1=half, 2=word; >2 illegal
hwdata  in  32  write data (data phase)
hreadyin  in  1  bus-level HREADY
hready_out  out  1  slave ready
hresp  out  1  0=OKAY, 1=ERROR
hrdata  out  32  registered read data
wr_en_ram  out  1  RAM write strobe
rd_en_ram  out  1  RAM read strobe
address_ram  out  RAM_AW  RAM word address
byte_en  out  4  write byte lanes
wr_data_ram  out  32  RAM write data
rd_data_ram  in  32  RAM read data

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state IDLE, hready_out=1, hresp=0, hrdata=0, wr_en_ram=0, rd_en_ram=0, address_ram=0, byte_en=0, wr_data_ram=0.
- Address-phase sample condition: hsel & hreadyin & htrans[1] on a rising edge. When sampled, latch haddr, hwrite and hsize. IDLE/BUSY or hsel=0 → OKAY, zero wait, no RAM activity.
- Error check, performed at sample time. A transfer is illegal if any of the following holds:
  - hsize>2;
  - it is misaligned (half with haddr[0]=1, or word with haddr[1:0]≠0);
  - haddr[31:RAM_AW+2]≠0.
- byte_en decode (from latched hsize and haddr[1:0], little-endian):
  - byte: one-hot at lane addr[1:0];
  - half: 0011 or 1100;
  - word: 1111.
- address_ram = latched haddr[RAM_AW+1:2].
- States:
  - IDLE: hready_out=1, hresp=0. Legal write → WR. Legal read → RD. Illegal → ERR1.
  - WR (one data-phase cycle): wr_en_ram=1, wr_data_ram=hwdata, byte_en valid, hready_out=1 (zero wait). Next state is chosen from the address phase sampled in this same cycle: IDLE, WR, RD or ERR1.
  - RD: rd_en_ram=1 in the first cycle only. Count RD_LAT cycles with hready_out=0. At the end of cycle RD_LAT, capture hrdata←rd_data_ram (full word; the master selects lanes) → RDONE.
  - RDONE: hready_out=1, hresp=0. Next state from any new sample, as in WR. Read data phase lasts RD_LAT+1 wait states plus the RDONE cycle.
  - ERR1: hready_out=0, hresp=1, no RAM strobes → ERR2.
  - ERR2: hready_out=1, hresp=1. A transfer sampled here is honoured; otherwise → IDLE.
- Address phases are sampled only when hready_out=1 (IDLE, WR, RDONE, ERR2). Inputs are ignored in RD and ERR1.
- Back-to-back write→read at the same address: the read is issued the cycle after wr_en_ram, so it returns the new data. No hazard logic is needed.
- Strobes: wr_en_ram and rd_en_ram are never high together, and each is never high for more than one cycle per transfer.
- hrdata holds its last captured value until the next read capture.
- Reset mid-transfer: outputs return immediately to reset values and any pending read is abandoned. No RAM strobe is asserted after rst rises.

Decomposition:
- Shared package ahb_pkg: HTRANS/HSIZE/HRESP encodings, state enum (IDLE, WR, RD, RDONE, ERR1, ERR2).
- One sub-module, ahb_byte_lane: combinational; takes hsize and addr[1:0], produces byte_en[3:0] and a misalign flag. It is reused by future slaves.

Test Plan:
- Write word 0xDEADBEEF to 0x10 → single-cycle wr_en_ram, address_ram=4, byte_en=1111, hready_out stays 1, hresp=0.
- Read 0x10, RD_LAT=1 → rd_en_ram one cycle, hready_out low for 2 cycles, then hrdata=0xDEADBEEF with hready_out=1.
- Halfword write 0xABCD at 0x12, then byte write 0x5A at 0x11 → byte_en=1100 then 0010. A word read at 0x10 returns 0xABCD5AEF.
- Misaligned word at 0x13, and out-of-range address 0x0000_1000 → each gives hready_out=0/hresp=1, then 1/1. No RAM strobes. The next legal transfer (sampled in ERR2) completes OKAY.
- Pipelined NONSEQ write 0x20 followed immediately by a read of 0x20 → read issued the cycle after the write and returns the written data. No idle cycle is inserted between the transfers.
- Assert rst during a RD wait state → outputs go to reset values asynchronously, hready_out=1, no further rd_en_ram. A fresh read after reset works.
